// File: rtl/rtc_display_shadow_pkg.sv
// Shared types and constants for the RTC display shadow and the screen top.
// The display set struct is the complete snapshot shown in one frame.
package rtc_display_shadow_pkg;

  localparam logic [3:0] ADDR_SS   = 4'd0;
  localparam logic [3:0] ADDR_MM   = 4'd1;
  localparam logic [3:0] ADDR_HH   = 4'd2;
  localparam logic [3:0] ADDR_DAY  = 4'd3;
  localparam logic [3:0] ADDR_MES  = 4'd4;
  localparam logic [3:0] ADDR_YEAR = 4'd5;
  localparam logic [3:0] ADDR_SS_T = 4'd6;
  localparam logic [3:0] ADDR_MM_T = 4'd7;
  localparam logic [3:0] ADDR_HH_T = 4'd8;
  localparam logic [3:0] ADDR_DOW  = 4'd9;
  localparam logic [3:0] ADDR_CTRL = 4'd10;

  localparam int CTRL_FMT  = 0;
  localparam int CTRL_AMPM = 1;
  localparam int CTRL_TEND = 2;

  localparam logic [7:0] RST_ZERO = 8'h00;
  localparam logic [7:0] RST_DAY  = 8'h01;
  localparam logic [7:0] RST_MES  = 8'h01;

  typedef struct packed {
    logic [7:0] ss;
    logic [7:0] mm;
    logic [7:0] hh;
    logic [7:0] day;
    logic [7:0] mes;
    logic [7:0] year;
    logic [7:0] ss_t;
    logic [7:0] mm_t;
    logic [7:0] hh_t;
    logic [2:0] dia_semana;
    logic       formato_hora;
    logic       am_pm;
    logic       timer_end;
  } disp_set_t;

  localparam disp_set_t DISP_RST = '{
    ss:           RST_ZERO,
    mm:           RST_ZERO,
    hh:           RST_ZERO,
    day:          RST_DAY,
    mes:          RST_MES,
    year:         RST_ZERO,
    ss_t:         RST_ZERO,
    mm_t:         RST_ZERO,
    hh_t:         RST_ZERO,
    dia_semana:   3'd0,
    formato_hora: 1'b0,
    am_pm:        1'b0,
    timer_end:    1'b0
  };

  function automatic logic bcd_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/rtc_display_shadow_vsync_edge.sv
// Registered vsync leading-edge detector.
// Polarity selects which transition marks the start of the pulse.
module vsync_edge_detect #(
  parameter bit ACT_LOW = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vsync_i,
  output logic edge_o
);

  localparam logic INACT = ACT_LOW ? 1'b1 : 1'b0;

  logic vsync_q;
  logic edge_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vsync_q <= INACT;
      edge_q  <= 1'b0;
    end else begin
      vsync_q <= vsync_i;
      edge_q  <= (vsync_i != INACT) && (vsync_q == INACT);
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/rtc_display_shadow.sv
// Shadow/display register pair for the clock screen; validated BCD writes
// land in the shadow and are copied to the display at the vsync edge.
module rtc_display_shadow
  import rtc_display_shadow_pkg::*;
#(
  parameter bit VSYNC_ACT_LOW = 1'b1,
  parameter int ADDR_W        = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_strobe,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              wr_hold,
  input  logic              vsync,
  output logic              wr_ack,
  output logic              bcd_error,
  output logic              commit_pulse,
  output logic [3:0]        digit1_HH,
  output logic [3:0]        digit0_HH,
  output logic [3:0]        digit1_MM,
  output logic [3:0]        digit0_MM,
  output logic [3:0]        digit1_SS,
  output logic [3:0]        digit0_SS,
  output logic [3:0]        digit1_DAY,
  output logic [3:0]        digit0_DAY,
  output logic [3:0]        digit1_MES,
  output logic [3:0]        digit0_MES,
  output logic [3:0]        digit1_YEAR,
  output logic [3:0]        digit0_YEAR,
  output logic [3:0]        digit1_HH_T,
  output logic [3:0]        digit0_HH_T,
  output logic [3:0]        digit1_MM_T,
  output logic [3:0]        digit0_MM_T,
  output logic [3:0]        digit1_SS_T,
  output logic [3:0]        digit0_SS_T,
  output logic              AM_PM,
  output logic [2:0]        dia_semana,
  output logic              formato_hora,
  output logic              timer_end
);

  disp_set_t sh_q, sh_d;
  disp_set_t disp_q;
  logic      dirty_q;
  logic      wr_ack_q, bcd_error_q, commit_q;
  logic      wr_ok;
  logic      vs_edge;
  logic      commit;

  vsync_edge_detect #(
    .ACT_LOW (VSYNC_ACT_LOW)
  ) u_edge (
    .clk_i   (clock),
    .rst_ni  (reset),
    .vsync_i (vsync),
    .edge_o  (vs_edge)
  );

  always_comb begin
    wr_ok = 1'b0;
    sh_d  = sh_q;
    if (wr_strobe) begin
      unique case (wr_addr)
        ADDR_W'(ADDR_SS): begin
          wr_ok = bcd_ok(wr_data);
          if (wr_ok) sh_d.ss = wr_data;
        end
        ADDR_W'(ADDR_MM): begin
          wr_ok = bcd_ok(wr_data);
          if (wr_ok) sh_d.mm = wr_data;
        end
        ADDR_W'(ADDR_HH): begin
          wr_ok = bcd_ok(wr_data);
          if (wr_ok) sh_d.hh = wr_data;
        end
        ADDR_W'(ADDR_DAY): begin
          wr_ok = bcd_ok(wr_data);
          if (wr_ok) sh_d.day = wr_data;
        end
        ADDR_W'(ADDR_MES): begin
          wr_ok = bcd_ok(wr_data);
          if (wr_ok) sh_d.mes = wr_data;
        end
        ADDR_W'(ADDR_YEAR): begin
          wr_ok = bcd_ok(wr_data);
          if (wr_ok) sh_d.year = wr_data;
        end
        ADDR_W'(ADDR_SS_T): begin
          wr_ok = bcd_ok(wr_data);
          if (wr_ok) sh_d.ss_t = wr_data;
        end
        ADDR_W'(ADDR_MM_T): begin
          wr_ok = bcd_ok(wr_data);
          if (wr_ok) sh_d.mm_t = wr_data;
        end
        ADDR_W'(ADDR_HH_T): begin
          wr_ok = bcd_ok(wr_data);
          if (wr_ok) sh_d.hh_t = wr_data;
        end
        ADDR_W'(ADDR_DOW): begin
          wr_ok = (wr_data[2:0] <= 3'd6);
          if (wr_ok) sh_d.dia_semana = wr_data[2:0];
        end
        ADDR_W'(ADDR_CTRL): begin
          wr_ok              = 1'b1;
          sh_d.formato_hora  = wr_data[CTRL_FMT];
          sh_d.am_pm         = wr_data[CTRL_AMPM];
          sh_d.timer_end     = wr_data[CTRL_TEND];
        end
        default: wr_ok = 1'b0;
      endcase
    end
  end

  assign commit = vs_edge && dirty_q && !wr_hold;

  // Commit copies the pre-write shadow; a same-cycle write keeps dirty set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sh_q        <= DISP_RST;
      disp_q      <= DISP_RST;
      dirty_q     <= 1'b0;
      wr_ack_q    <= 1'b0;
      bcd_error_q <= 1'b0;
      commit_q    <= 1'b0;
    end else begin
      sh_q        <= sh_d;
      wr_ack_q    <= wr_strobe && wr_ok;
      bcd_error_q <= wr_strobe && !wr_ok;
      commit_q    <= commit;
      if (commit) disp_q <= sh_q;
      if (wr_strobe && wr_ok) dirty_q <= 1'b1;
      else if (commit)        dirty_q <= 1'b0;
    end
  end

  assign wr_ack       = wr_ack_q;
  assign bcd_error    = bcd_error_q;
  assign commit_pulse = commit_q;

  assign digit1_HH   = disp_q.hh[7:4];
  assign digit0_HH   = disp_q.hh[3:0];
  assign digit1_MM   = disp_q.mm[7:4];
  assign digit0_MM   = disp_q.mm[3:0];
  assign digit1_SS   = disp_q.ss[7:4];
  assign digit0_SS   = disp_q.ss[3:0];
  assign digit1_DAY  = disp_q.day[7:4];
  assign digit0_DAY  = disp_q.day[3:0];
  assign digit1_MES  = disp_q.mes[7:4];
  assign digit0_MES  = disp_q.mes[3:0];
  assign digit1_YEAR = disp_q.year[7:4];
  assign digit0_YEAR = disp_q.year[3:0];
  assign digit1_HH_T = disp_q.hh_t[7:4];
  assign digit0_HH_T = disp_q.hh_t[3:0];
  assign digit1_MM_T = disp_q.mm_t[7:4];
  assign digit0_MM_T = disp_q.mm_t[3:0];
  assign digit1_SS_T = disp_q.ss_t[7:4];
  assign digit0_SS_T = disp_q.ss_t[3:0];

  assign AM_PM        = disp_q.am_pm;
  assign dia_semana   = disp_q.dia_semana;
  assign formato_hora = disp_q.formato_hora;
  assign timer_end    = disp_q.timer_end;

endmodule

// File: doc/rtc_display_shadow.md
Name: rtc_display_shadow

Overview:
- Sits directly upstream of the clock-screen top level, between the RTC register-read controller and the text/graphics generators.
- Captures BCD bytes written by the RTC controller into shadow registers and validates each byte.
- Copies all shadow registers to the display registers atomically at the start of a vertical sync pulse, so a frame never shows a half-updated time/date/timer.
- Drives the 18 digit nibbles plus the AM_PM, dia_semana, formato_hora and timer_end inputs consumed by the screen top.

Parameters:
- VSYNC_ACT_LOW, 1, 1: the vsync pulse is active-low, so commit is on its falling edge. 0: commit on the rising edge.
- ADDR_W, 4, width of the register address bus.

Ports:
- clock  in  1  system clock, same domain as the VGA timing generator
- reset  in  1  asynchronous, active-low reset
- wr_strobe  in  1  one-cycle write request from the RTC controller
- wr_addr  in  ADDR_W  register address
- wr_data  in  8  BCD byte: [7:4] tens, [3:0] units
- wr_hold  in  1  high while the controller writes a full register set; defers commit
- vsync  in  1  vsync from the timing generator
- wr_ack  out  1  one-cycle acknowledge, asserted the cycle after an accepted write
- bcd_error  out  1  one-cycle pulse, asserted the cycle after a rejected write
- commit_pulse  out  1  one-cycle pulse on the cycle the display registers update
- digit1_X, digit0_X  out  4 each  tens/units for X in {HH, MM, SS, DAY, MES, YEAR, HH_T, MM_T, SS_T}; 18 outputs
- AM_PM  out  1  0 = AM, 1 = PM
- dia_semana  out  3  day of week, 0..6
- formato_hora  out  1  0 = 24 h, 1 = 12 h
- timer_end  out  1  timer-expired flag

Behaviour:
- Address map:
  - 0 SS, 1 MM, 2 HH, 3 DAY, 4 MES, 5 YEAR, 6 SS_T, 7 MM_T, 8 HH_T
  - 9 dia_semana = data[2:0]
  - 10 control: bit0 formato_hora, bit1 AM_PM, bit2 timer_end
  - 11..15 are reserved.
- Write validation, applied at the cycle wr_strobe is sampled high:
  - Addresses 0..8: accepted only if both nibbles are ≤ 9.
  - Address 9: accepted only if data[2:0] ≤ 6.
  - Address 10: always accepted.
  - Reserved address or failed check: shadow unchanged, bcd_error pulses next cycle, wr_ack stays low.
- Accepted write: shadow register is updated, the dirty flag is set, and wr_ack pulses the next cycle.
- wr_strobe on consecutive cycles is legal; every strobe gets exactly one wr_ack or one bcd_error.
- Commit event:
  - The vsync edge is detected with a one-flop delay; vsync_q resets to the inactive level.
  - On the detected edge, if dirty = 1 and wr_hold = 0: display registers load the shadow, dirty clears, and commit_pulse is high for that cycle.
  - New outputs appear on the cycle after the edge is registered.
- Deferred commit: if wr_hold = 1 at the edge, no commit happens and dirty is kept. The next edge with wr_hold = 0 commits. There is no mid-frame commit.
- Write in the same cycle as commit: the commit copies the pre-write shadow; the new write lands in the shadow and dirty stays 1.
- Clean edge: an edge with dirty = 0 produces no commit_pulse and no output change.
- Reset (async assert, sync release):
  - Shadow and display both reset to 00:00:00, DAY = 01, MES = 01, YEAR = 00, timer 00:00:00.
  - dia_semana = 0, formato_hora = 0, AM_PM = 0, timer_end = 0.
  - dirty = 0; wr_ack, bcd_error and commit_pulse = 0.
  - Reset mid-burst discards all uncommitted writes.
- No semantic range checks beyond BCD (e.g. HH = 25 is accepted); range enforcement belongs to the RTC controller.

Decomposition:
- Shared package holds:
  - the address constants (ADDR_SS..ADDR_CTRL)
  - control bit indices
  - reset BCD values
  - a record/struct for the full 9-field + flags display set, reused by the screen top.
- One sub-module: vsync_edge_detect (polarity parameter, registered edge pulse).

Test Plan:
- Reset release, no writes, 10 frames -> outputs 00:00:00, 01/01/00, all flags 0; commit_pulse never asserted.
- Write addr2 = 0x23, addr1 = 0x45, addr0 = 0x07, then a vsync edge -> wr_ack pulses 3 times; digits show 23:45:07 only after the edge; commit_pulse = 1 exactly once.
- Write addr3 = 0x3A -> bcd_error pulses, wr_ack = 0; after the next edge DAY remains 01 and no commit occurs.
- wr_hold = 1, write addr5 = 0x16, two vsync edges, then drop wr_hold -> YEAR stays 00 through both edges and becomes 16 at the third edge.
- Write addr10 = 0x05 in the same cycle as a commit edge (dirty already set by addr9 = 0x03) -> dia_semana = 3 after that edge; formato_hora = 1 and timer_end = 1 only after the following edge.
- Assert reset mid-frame after uncommitted writes -> all outputs return to reset values immediately; the next edge produces no commit.
